// File: rtl/sram_init_engine.sv
// sram_init_engine: sweeps a single-port RAM from address 0 to DEPTH-1,
// either writing (identity, constant, repeating key) or reading back and
// checking for identity contents. Completion is reported via busy/done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; RAM outputs and done held at 0
// S_FILL  | one write per cycle, idx = 0 .. DEPTH-1
// S_VERIFY| one read per cycle, idx = 0 .. DEPTH-1
// S_DRAIN | READ_LAT cycles letting the last reads reach the comparator
// S_DONE  | sweep finished; done=1 until start or abort
//
// RAM-facing outputs are registered from the state they describe, so they
// trail the state register by one cycle.
module sram_init_engine #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int KEY_BYTES = 3,
  parameter int READ_LAT  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    mode,
  input  logic [DATA_W-1:0]             fill_value,
  input  logic [KEY_BYTES*DATA_W-1:0]   key,
  input  logic [DATA_W-1:0]             q,
  output logic [ADDR_W-1:0]             address,
  output logic [DATA_W-1:0]             data,
  output logic                          wren,
  output logic                          rden,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [ADDR_W-1:0]             err_addr
);

  localparam int IDX_W  = ADDR_W + 1;
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int DRN_W  = $clog2(READ_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VERIFY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                        state;
  logic [IDX_W-1:0]              idx;
  logic [KIDX_W-1:0]             kidx;
  logic [DRN_W-1:0]              drn_cnt;
  logic [1:0]                    mode_r;
  logic [DATA_W-1:0]             fill_r;
  logic [KEY_BYTES*DATA_W-1:0]   key_r;
  logic                          pipe_vld  [READ_LAT];
  logic [ADDR_W-1:0]             pipe_addr [READ_LAT];
  logic                          last_idx;
  logic [DATA_W-1:0]             key_word;
  logic [DATA_W-1:0]             fill_word;

  assign last_idx = (idx == IDX_W'(DEPTH - 1));

  // Select the write word for the current index; key word 0 is the top slice.
  always_comb begin
    key_word = DATA_W'(key_r >> ((KEY_BYTES - 1 - int'(kidx)) * DATA_W));
    case (mode_r)
      2'd0:    fill_word = DATA_W'(idx);
      2'd1:    fill_word = fill_r;
      default: fill_word = key_word;
    endcase
  end

  // Read-tracking pipeline: each issued read address rides alongside the RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
      end
    end else begin
      pipe_vld[0]  <= rden;
      pipe_addr[0] <= address;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  // Sweep FSM with registered RAM outputs, handshake and sticky error capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      kidx     <= '0;
      drn_cnt  <= '0;
      mode_r   <= '0;
      fill_r   <= '0;
      key_r    <= '0;
      address  <= '0;
      data     <= '0;
      wren     <= 1'b0;
      rden     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_addr <= '0;
    end else if (abort) begin
      state   <= S_IDLE;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      rden    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Only the first mismatch is recorded; a start below clears it again.
      if (pipe_vld[READ_LAT-1] && !error &&
          (q != DATA_W'(pipe_addr[READ_LAT-1]))) begin
        error    <= 1'b1;
        err_addr <= pipe_addr[READ_LAT-1];
      end
      case (state)
        S_IDLE, S_DONE: begin
          address <= '0;
          data    <= '0;
          wren    <= 1'b0;
          rden    <= 1'b0;
          busy    <= 1'b0;
          done    <= (state == S_DONE);
          if (start) begin
            mode_r   <= mode;
            fill_r   <= fill_value;
            key_r    <= key;
            idx      <= '0;
            kidx     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_addr <= '0;
            state    <= (mode == 2'd3) ? S_VERIFY : S_FILL;
          end
        end
        S_FILL: begin
          address <= idx[ADDR_W-1:0];
          data    <= fill_word;
          wren    <= 1'b1;
          rden    <= 1'b0;
          busy    <= 1'b1;
          done    <= 1'b0;
          kidx    <= (kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
          if (last_idx) begin
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_VERIFY: begin
          address <= idx[ADDR_W-1:0];
          data    <= '0;
          wren    <= 1'b0;
          rden    <= 1'b1;
          busy    <= 1'b1;
          done    <= 1'b0;
          if (last_idx) begin
            state   <= S_DRAIN;
            drn_cnt <= DRN_W'(READ_LAT - 1);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DRAIN: begin
          address <= '0;
          data    <= '0;
          wren    <= 1'b0;
          rden    <= 1'b0;
          busy    <= 1'b1;
          done    <= 1'b0;
          if (drn_cnt == '0) begin
            state <= S_DONE;
          end else begin
            drn_cnt <= drn_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_init_engine.sv
// Testbench for sram_init_engine: three instances (256-deep/READ_LAT=1,
// 16-deep/READ_LAT=2/2-byte key, 1-deep) each on its own behavioural RAM.
// Expected behaviour comes from a cycle-indexed model of a sweep and a
// shadow copy of each RAM's contents.
module tb_sram_init_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic        abort;
  logic [1:0]  mode;
  logic [7:0]  fill_value;
  logic [23:0] key;

  logic [7:0] addr0, data0, erra0, q0;
  logic       wren0, rden0, busy0, done0, error0;
  logic [3:0] addr1, erra1;
  logic [7:0] data1, q1, q1a;
  logic       wren1, rden1, busy1, done1, error1;
  logic [3:0] addr2, erra2;
  logic [7:0] data2, q2;
  logic       wren2, rden2, busy2, done2, error2;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [7:0] shadow [3][256];

  logic       bd_we;
  int         bd_sel;
  logic [7:0] bd_addr, bd_data;

  int sel;
  logic [7:0] s_addr, s_data, s_erra;
  logic       s_wren, s_rden, s_busy, s_done, s_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_init_engine u0 (
    .clk(clk), .reset(reset), .start(start[0]), .abort(abort), .mode(mode),
    .fill_value(fill_value), .key(key), .q(q0), .address(addr0), .data(data0),
    .wren(wren0), .rden(rden0), .busy(busy0), .done(done0), .error(error0),
    .err_addr(erra0));

  sram_init_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .KEY_BYTES(2), .READ_LAT(2)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .abort(abort), .mode(mode),
    .fill_value(fill_value), .key(key[15:0]), .q(q1), .address(addr1), .data(data1),
    .wren(wren1), .rden(rden1), .busy(busy1), .done(done1), .error(error1),
    .err_addr(erra1));

  sram_init_engine #(.ADDR_W(4), .DATA_W(8), .DEPTH(1), .KEY_BYTES(3), .READ_LAT(1)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .abort(abort), .mode(mode),
    .fill_value(fill_value), .key(key), .q(q2), .address(addr2), .data(data2),
    .wren(wren2), .rden(rden2), .busy(busy2), .done(done2), .error(error2),
    .err_addr(erra2));

  // RAM models: synchronous write, read data READ_LAT cycles after the address cycle.
  always @(posedge clk) begin
    if (wren0) mem0[addr0] <= data0;
    else if (bd_we && bd_sel == 0) mem0[bd_addr] <= bd_data;
    q0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (wren1) mem1[addr1] <= data1;
    else if (bd_we && bd_sel == 1) mem1[bd_addr[3:0]] <= bd_data;
    q1a <= mem1[addr1];
    q1  <= q1a;
  end

  always @(posedge clk) begin
    if (wren2) mem2[addr2] <= data2;
    else if (bd_we && bd_sel == 2) mem2[bd_addr[3:0]] <= bd_data;
    q2 <= mem2[addr2];
  end

  // Route the selected instance's outputs to one set of check signals.
  always_comb begin
    case (sel)
      1: begin
        s_addr = {4'b0, addr1}; s_data = data1; s_erra = {4'b0, erra1};
        s_wren = wren1; s_rden = rden1; s_busy = busy1; s_done = done1; s_error = error1;
      end
      2: begin
        s_addr = {4'b0, addr2}; s_data = data2; s_erra = {4'b0, erra2};
        s_wren = wren2; s_rden = rden2; s_busy = busy2; s_done = done2; s_error = error2;
      end
      default: begin
        s_addr = addr0; s_data = data0; s_erra = erra0;
        s_wren = wren0; s_rden = rden0; s_busy = busy0; s_done = done0; s_error = error0;
      end
    endcase
  end

  function automatic int depth_of(int s);
    return (s == 0) ? 256 : (s == 1) ? 16 : 1;
  endfunction

  function automatic int rl_of(int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int kb_of(int s);
    return (s == 1) ? 2 : 3;
  endfunction

  // Word the sweep should write at address a.
  function automatic logic [7:0] exp_data(int s, logic [1:0] m, logic [7:0] fv,
                                          logic [23:0] k, int a);
    int kb;
    int j;
    kb = kb_of(s);
    case (m)
      2'd0: return 8'(a);
      2'd1: return fv;
      default: begin
        j = a % kb;
        return 8'(k >> (8 * (kb - 1 - j)));
      end
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Compare every output against the model, c cycles after the start edge.
  task automatic cyc_check(int s, logic [1:0] m, logic [7:0] fv, logic [23:0] k, int c,
                           int exp_done, logic exp_err, int exp_ea);
    int d;
    int rl;
    logic ew, er, eb, edn, ee;
    logic [7:0] ea, ed;
    logic [20:0] msk, act, exv;
    d   = depth_of(s);
    rl  = rl_of(s);
    ew  = (m != 2'd3) && c >= 1 && c <= d;
    er  = (m == 2'd3) && c >= 1 && c <= d;
    eb  = c >= 1 && c < exp_done;
    edn = c >= exp_done;
    ee  = (m == 2'd3) && exp_err && (c >= exp_ea + rl + 2);
    ea  = (c >= 1 && c <= d) ? 8'(c - 1) : 8'h00;
    ed  = ew ? exp_data(s, m, fv, k, c - 1) : 8'h00;
    msk = er ? 21'h1FFF00 : 21'h1FFFFF;
    act = {s_wren, s_rden, s_busy, s_done, s_error, s_addr, s_data};
    exv = {ew, er, eb, edn, ee, ea, ed};
    chk($sformatf("u%0d_m%0d_cyc%0d{wren,rden,busy,done,error,addr,data}", s, m, c),
        32'(act & msk), 32'(exv & msk));
  endtask

  task automatic bd_write(int s, int a, logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_sel = s; bd_addr = 8'(a); bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
    shadow[s][a] = d;
  endtask

  // One complete sweep from start to a few cycles into DONE.
  task automatic run_sweep(int s, logic [1:0] m, logic [7:0] fv, logic [23:0] k,
                           int exp_done, logic exp_err, int exp_ea);
    sel = s;
    @(negedge clk);
    mode = m; fill_value = fv; key = k; start[s] = 1'b1;
    @(negedge clk);
    start = '0;
    mode = 2'($urandom_range(0, 3)); fill_value = 8'($urandom); key = 24'($urandom);
    for (int c = 0; c <= exp_done + 2; c++) begin
      if (c > 0) @(negedge clk);
      cyc_check(s, m, fv, k, c, exp_done, exp_err, exp_ea);
      start[s] = (c == 3 && exp_done > 6);
    end
    start = '0;
    chk($sformatf("u%0d_m%0d_err_addr", s, m), 32'(s_erra), exp_err ? 32'(exp_ea) : 32'd0);
    if (m != 2'd3)
      for (int a = 0; a < depth_of(s); a++) shadow[s][a] = exp_data(s, m, fv, k, a);
  endtask

  typedef struct {
    int          s;
    logic [1:0]  m;
    logic [7:0]  fv;
    logic [23:0] k;
    int          nc;
    int          ca0;
    logic [7:0]  cd0;
    int          ca1;
    logic [7:0]  cd1;
    int          exp_done;
    logic        exp_err;
    int          exp_ea;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 2'd2, 8'h00, 24'h030201, 0, 0,  8'h00, 0,   8'h00, 257, 1'b0, 0};
    tbl[1]  = '{0, 2'd0, 8'h00, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 257, 1'b0, 0};
    tbl[2]  = '{0, 2'd3, 8'h00, 24'h000000, 2, 17, 8'hAA, 200, 8'h00, 258, 1'b1, 17};
    tbl[3]  = '{0, 2'd1, 8'h5A, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 257, 1'b0, 0};
    tbl[4]  = '{1, 2'd0, 8'h00, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 17,  1'b0, 0};
    tbl[5]  = '{1, 2'd3, 8'h00, 24'h000000, 1, 9,  8'h09, 0,   8'h00, 19,  1'b0, 0};
    tbl[6]  = '{1, 2'd3, 8'h00, 24'h000000, 1, 15, 8'h3C, 0,   8'h00, 19,  1'b1, 15};
    tbl[7]  = '{1, 2'd2, 8'h00, 24'h00BEEF, 0, 0,  8'h00, 0,   8'h00, 17,  1'b0, 0};
    tbl[8]  = '{2, 2'd0, 8'h00, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 2,   1'b0, 0};
    tbl[9]  = '{2, 2'd3, 8'h00, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 3,   1'b0, 0};
    tbl[10] = '{2, 2'd1, 8'h77, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 2,   1'b0, 0};
    tbl[11] = '{2, 2'd3, 8'h00, 24'h000000, 0, 0,  8'h00, 0,   8'h00, 3,   1'b1, 0};

    reset = 1'b1; start = '0; abort = 1'b0; mode = 2'd0; fill_value = 8'h00; key = 24'h0;
    bd_we = 1'b0; bd_sel = 0; bd_addr = 8'h00; bd_data = 8'h00; sel = 0;
    repeat (3) @(negedge clk);
    chk("reset_u0", {wren0, rden0, busy0, done0, error0, addr0, data0, erra0}, 32'd0);
    chk("reset_u1", {wren1, rden1, busy1, done1, error1, addr1, data1, erra1}, 32'd0);
    chk("reset_u2", {wren2, rden2, busy2, done2, error2, addr2, data2, erra2}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_u0", {wren0, rden0, busy0, done0, error0, addr0, data0}, 32'd0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].nc > 0) bd_write(tbl[i].s, tbl[i].ca0, tbl[i].cd0);
      if (tbl[i].nc > 1) bd_write(tbl[i].s, tbl[i].ca1, tbl[i].cd1);
      run_sweep(tbl[i].s, tbl[i].m, tbl[i].fv, tbl[i].k, tbl[i].exp_done,
                tbl[i].exp_err, tbl[i].exp_ea);
    end

    // Abort together with start at sweep cycle 100 of a constant fill.
    sel = 0;
    @(negedge clk);
    mode = 2'd1; fill_value = 8'h5A; start[0] = 1'b1;
    @(negedge clk);
    start = '0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      cyc_check(0, 2'd1, 8'h5A, 24'h0, c, 257, 1'b0, 0);
    end
    abort = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = '0;
    chk("abort_stop", {wren0, rden0, busy0, done0, addr0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_idle%0d", i), {wren0, rden0, busy0, done0}, 32'd0);
    end
    for (int a = 0; a < 100; a++) shadow[0][a] = 8'h5A;
    run_sweep(0, 2'd1, 8'h5A, 24'h0, 257, 1'b0, 0);

    // Asynchronous reset in the middle of a sweep (RAM already holds 5A).
    @(negedge clk);
    mode = 2'd1; fill_value = 8'h5A; start[0] = 1'b1;
    @(negedge clk);
    start = '0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      cyc_check(0, 2'd1, 8'h5A, 24'h0, c, 257, 1'b0, 0);
    end
    #1 reset = 1'b1;
    #1 chk("reset_async", {wren0, rden0, busy0, done0, addr0, data0}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset%0d", i), {wren0, rden0, busy0, done0}, 32'd0);
    end

    // Randomised sweeps against the shadow-memory model.
    for (int it = 0; it < 24; it++) begin
      int s;
      int d;
      int ea;
      int exp_done;
      logic [1:0] m;
      logic [7:0] fv;
      logic [23:0] k;
      s  = $urandom_range(0, 2);
      d  = depth_of(s);
      m  = 2'($urandom_range(0, 3));
      fv = 8'($urandom);
      k  = 24'($urandom);
      if ($urandom_range(0, 2) == 0)
        bd_write(s, $urandom_range(0, d - 1), 8'($urandom));
      ea = -1;
      if (m == 2'd3) begin
        for (int a = 0; a < d; a++)
          if (ea < 0 && shadow[s][a] != 8'(a)) ea = a;
        exp_done = d + rl_of(s) + 1;
      end else begin
        exp_done = d + 1;
      end
      run_sweep(s, m, fv, k, exp_done, ea >= 0, (ea >= 0) ? ea : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
